// File: rtl/bc_horner_seq_pkg.sv
// Shared definitions for the Horner-rule control block (BC), its datapath (BO) and benches.
package bc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_WAIT = 3'd3,
        ST_ACC  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } bc_state_e;

    // H-input mux select values seen by the datapath
    localparam logic M_H_COEF = 1'b0;
    localparam logic M_H_MAC  = 1'b1;

endpackage

// File: rtl/bc_horner_seq_timeout.sv
// Clear/enable WAIT-cycle counter; hit_o flags the last permitted WAIT cycle.
module bc_timeout
    import bc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    if (TIMEOUT == 0) begin : g_disabled
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, clr_i, en_i};
        assign hit_o     = 1'b0;
    end else begin : g_counter
        localparam int unsigned CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
                // saturates at TIMEOUT instead of wrapping
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign hit_o = (cnt_q == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/bc_horner_seq.sv
// Moore control FSM sequencing H = a[GRAU]; H = H*x + a[i] for i = GRAU-1 .. 0.
module bc_horner_seq
    import bc_pkg::*;
#(
    parameter int unsigned GRAU      = 3,
    parameter int unsigned IDX_W     = (GRAU < 1) ? 1 : $clog2(GRAU + 1),
    parameter int unsigned TIMEOUT   = 15,
    parameter bit          HOLD_DONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             permit_i,
    input  logic             cancel_i,
    input  logic             mul_ok_i,
    output logic             ready_o,
    output logic             feito_o,
    output logic             erro_o,
    output logic             lx_o,
    output logic             lh_o,
    output logic             m_h_o,
    output logic             mul_start_o,
    output logic [IDX_W-1:0] coef_idx_o
);

    bc_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             to_hit;

    bc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_MUL),
        .en_i  (state_q == ST_WAIT),
        .hit_o (to_hit)
    );

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: if (permit_i) begin
                state_d = ST_LOAD;
                idx_d   = IDX_W'(GRAU);
            end
            ST_LOAD: if (GRAU == 0) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_MUL;
                idx_d   = idx_q - 1'b1;
            end
            ST_MUL:  state_d = ST_WAIT;
            ST_WAIT: if (mul_ok_i) begin
                state_d = ST_ACC;
            end else if (to_hit) begin
                state_d = ST_ERR;
            end
            ST_ACC: if (idx_q == '0) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_MUL;
                idx_d   = idx_q - 1'b1;
            end
            // a held permit keeps DONE so it cannot immediately restart the block
            ST_DONE: if (!HOLD_DONE || !permit_i) begin
                state_d = ST_IDLE;
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign feito_o     = (state_q == ST_DONE);
    assign erro_o      = (state_q == ST_ERR);
    assign lx_o        = (state_q == ST_LOAD);
    assign lh_o        = (state_q == ST_LOAD) || (state_q == ST_ACC);
    assign m_h_o       = (state_q == ST_ACC) ? M_H_MAC : M_H_COEF;
    assign mul_start_o = (state_q == ST_MUL);
    assign coef_idx_o  = idx_q;

endmodule

// File: tb/tb_bc_horner_seq.sv
// Randomised bench for bc_horner_seq: expected per-cycle output traces built from Horner's schedule.
module tb_bc_horner_seq;

    localparam int GA = 3;
    localparam int TA = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_permit, a_cancel, a_mul_ok;
    logic       a_ready, a_feito, a_erro, a_lx, a_lh, a_mh, a_ms;
    logic [1:0] a_idx;
    logic       b_permit, b_cancel, b_mul_ok;
    logic       b_ready, b_feito, b_erro, b_lx, b_lh, b_mh, b_ms;
    logic [0:0] b_idx;
    logic [8:0] a_vec, b_vec;

    bc_horner_seq #(.GRAU(GA), .TIMEOUT(TA), .HOLD_DONE(1'b0)) u_a (
        .clk(clk), .rst(rst), .permit_i(a_permit), .cancel_i(a_cancel), .mul_ok_i(a_mul_ok),
        .ready_o(a_ready), .feito_o(a_feito), .erro_o(a_erro), .lx_o(a_lx), .lh_o(a_lh),
        .m_h_o(a_mh), .mul_start_o(a_ms), .coef_idx_o(a_idx)
    );

    bc_horner_seq #(.GRAU(0), .TIMEOUT(0), .HOLD_DONE(1'b1)) u_b (
        .clk(clk), .rst(rst), .permit_i(b_permit), .cancel_i(b_cancel), .mul_ok_i(b_mul_ok),
        .ready_o(b_ready), .feito_o(b_feito), .erro_o(b_erro), .lx_o(b_lx), .lh_o(b_lh),
        .m_h_o(b_mh), .mul_start_o(b_ms), .coef_idx_o(b_idx)
    );

    assign a_vec = {a_ready, a_feito, a_erro, a_lx, a_lh, a_mh, a_ms, a_idx};
    assign b_vec = {b_ready, b_feito, b_erro, b_lx, b_lh, b_mh, b_ms, 1'b0, b_idx};

    // one clock edge: inputs sampled at that edge and the outputs expected after it
    typedef struct packed {
        logic       p;
        logic       c;
        logic       m;
        logic [8:0] e;
    } step_t;

    step_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    idle_idx[2];

    // output vector {ready, feito, erro, lx, lh, m_h, mul_start, coef_idx}
    function automatic logic [8:0] v_idle(input int i); return {7'b1000000, 2'(i)}; endfunction
    function automatic logic [8:0] v_load(input int i); return {7'b0001100, 2'(i)}; endfunction
    function automatic logic [8:0] v_mul (input int i); return {7'b0000001, 2'(i)}; endfunction
    function automatic logic [8:0] v_wait(input int i); return {7'b0000000, 2'(i)}; endfunction
    function automatic logic [8:0] v_acc (input int i); return {7'b0000110, 2'(i)}; endfunction
    function automatic logic [8:0] v_err (input int i); return {7'b0010000, 2'(i)}; endfunction
    function automatic logic [8:0] v_done();            return 9'b010000000;           endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic step_t mk(input logic p, input logic c, input logic m, input logic [8:0] e);
        step_t s;
        s.p = p; s.c = c; s.m = m; s.e = e;
        return s;
    endfunction

    // Queue one full evaluation of degree g; to_term>0 makes that term time out,
    // cancel_pos>=0 aborts at that edge, hold_cycles keeps permit high in DONE.
    task automatic build_eval(input int sel, input int g, input int tmax, input int fixed_lat,
                              input int to_term, input int hold_cycles, input int cancel_pos,
                              input bit hold_mode);
        step_t t[$];
        int    idx, w, end_idx;
        bit    err;
        err     = 1'b0;
        end_idx = 0;
        idx     = g;
        t.push_back(mk(1'b1, 1'b0, rbit(), v_load(g)));
        for (int term = 1; term <= g && !err; term++) begin
            idx = g - term;
            t.push_back(mk(rbit(), 1'b0, rbit(), v_mul(idx)));
            t.push_back(mk(rbit(), 1'b0, rbit(), v_wait(idx)));
            if (term == to_term) begin
                for (int j = 1; j < tmax; j++) t.push_back(mk(rbit(), 1'b0, 1'b0, v_wait(idx)));
                t.push_back(mk(rbit(), 1'b0, 1'b0, v_err(idx)));
                err     = 1'b1;
                end_idx = idx;
            end else begin
                w = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(tmax, 1));
                for (int j = 1; j < w; j++) t.push_back(mk(rbit(), 1'b0, 1'b0, v_wait(idx)));
                t.push_back(mk(rbit(), 1'b0, 1'b1, v_acc(idx)));
            end
        end
        if (err) begin
            t.push_back(mk(rbit(), 1'b0, rbit(), v_idle(end_idx)));
        end else if (hold_mode) begin
            t.push_back(mk(hold_cycles > 0, 1'b0, rbit(), v_done()));
            for (int j = 0; j < hold_cycles; j++) t.push_back(mk(1'b1, 1'b0, rbit(), v_done()));
            t.push_back(mk(1'b0, 1'b0, rbit(), v_idle(0)));
        end else begin
            t.push_back(mk(rbit(), 1'b0, rbit(), v_done()));
            t.push_back(mk(rbit(), 1'b0, rbit(), v_idle(0)));
        end
        for (int k = 0; k < t.size(); k++) begin
            if (k == cancel_pos) begin
                q.push_back(mk(1'b1, 1'b1, rbit(), v_idle(0)));
                idle_idx[sel] = 0;
                return;
            end
            q.push_back(t[k]);
        end
        idle_idx[sel] = end_idx;
    endtask

    task automatic build_idle(input int sel, input int n);
        for (int k = 0; k < n; k++) q.push_back(mk(1'b0, 1'b0, rbit(), v_idle(idle_idx[sel])));
    endtask

    task automatic drive_step(input int sel, input step_t s, output logic [8:0] obs);
        @(negedge clk);
        a_permit = (sel == 0) ? s.p : 1'b0;
        a_cancel = (sel == 0) ? s.c : 1'b0;
        a_mul_ok = (sel == 0) ? s.m : 1'b0;
        b_permit = (sel == 1) ? s.p : 1'b0;
        b_cancel = (sel == 1) ? s.c : 1'b0;
        b_mul_ok = (sel == 1) ? s.m : 1'b0;
        @(posedge clk);
        #1;
        obs = (sel == 0) ? a_vec : b_vec;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        {a_permit, a_cancel, a_mul_ok, b_permit, b_cancel, b_mul_ok} = '0;
        #3;
        total++;
        if (a_vec !== v_idle(0)) begin
            bad++; $display("FAIL reset_a: got %b want %b", a_vec, v_idle(0));
        end
        total++;
        if (b_vec !== v_idle(0)) begin
            bad++; $display("FAIL reset_b: got %b want %b", b_vec, v_idle(0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_idx[0] = 0;
        idle_idx[1] = 0;
    endtask

    task automatic test_latency_g3();
        step_t      s;
        logic [8:0] obs;
        int         k, first_feito, n_ms;
        k = 0; first_feito = -1; n_ms = 0;
        build_eval(0, GA, TA, 1, 0, 0, -1, 1'b0);
        build_idle(0, 2);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive_step(0, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL latency_trace step %0d: got %b want %b", k, obs, s.e);
            end
            if (obs[2]) n_ms++;
            if (obs[7] && first_feito < 0) first_feito = k;
            k++;
        end
        total++;
        if (first_feito !== 10) begin
            bad++; $display("FAIL latency_feito_edge: got %0d want 10", first_feito);
        end
        total++;
        if (n_ms !== 3) begin
            bad++; $display("FAIL latency_mul_starts: got %0d want 3", n_ms);
        end
    endtask

    task automatic test_grau0();
        step_t      s;
        logic [8:0] obs;
        int         k;
        k = 0;
        build_idle(1, 1);
        build_eval(1, 0, 1, 1, 0, 0, -1, 1'b1);
        build_idle(1, 2);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive_step(1, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL grau0 step %0d: got %b want %b", k, obs, s.e);
            end
            k++;
        end
    endtask

    task automatic test_timeout();
        step_t      s;
        logic [8:0] obs;
        int         k;
        for (int r = 0; r < 3; r++) begin
            k = 0;
            build_eval(0, GA, TA, 0, int'($urandom_range(GA, 1)), 0, -1, 1'b0);
            build_idle(0, 2);
            while (q.size() > 0) begin
                s = q.pop_front();
                drive_step(0, s, obs);
                total++;
                if (obs !== s.e) begin
                    bad++; $display("FAIL timeout run %0d step %0d: got %b want %b", r, k, obs, s.e);
                end
                k++;
            end
        end
    endtask

    task automatic test_cancel();
        step_t      s;
        logic [8:0] obs;
        int         k;
        k = 0;
        // latency 3 per term: edge 9 is sampled in the second WAIT cycle of term 2
        build_eval(0, GA, TA, 3, 0, 0, 9, 1'b0);
        build_idle(0, 2);
        build_eval(0, GA, TA, 0, 0, 0, 0, 1'b0);
        build_idle(0, 2);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive_step(0, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL cancel step %0d: got %b want %b", k, obs, s.e);
            end
            k++;
        end
    endtask

    task automatic test_hold_done();
        step_t      s;
        logic [8:0] obs;
        int         k;
        k = 0;
        build_eval(1, 0, 1, 1, 0, 5, -1, 1'b1);
        build_idle(1, 3);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive_step(1, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL hold_done step %0d: got %b want %b", k, obs, s.e);
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        step_t      s;
        logic [8:0] obs;
        build_eval(0, GA, TA, 1, 0, 0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            s = q.pop_front();
            drive_step(0, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL async_pre step %0d: got %b want %b", k, obs, s.e);
            end
        end
        q.delete();
        #2 rst = 1'b0;
        #1;
        total++;
        if (a_vec !== v_idle(0)) begin
            bad++; $display("FAIL async_reset_now: got %b want %b", a_vec, v_idle(0));
        end
        {a_permit, a_cancel, a_mul_ok} = '0;
        @(posedge clk); #1;
        total++;
        if (a_vec !== v_idle(0)) begin
            bad++; $display("FAIL async_reset_held: got %b want %b", a_vec, v_idle(0));
        end
        @(negedge clk);
        rst = 1'b1;
        idle_idx[0] = 0;
        build_idle(0, 1);
        build_eval(0, GA, TA, 0, 0, 0, -1, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            s = q.pop_front();
            drive_step(0, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL async_resume step %0d: got %b want %b", k, obs, s.e);
            end
        end
    endtask

    task automatic test_random();
        step_t      s;
        logic [8:0] obs;
        int         to_term, cpos;
        for (int r = 0; r < 12; r++) begin
            to_term = ($urandom_range(3, 0) == 0) ? int'($urandom_range(GA, 1)) : 0;
            cpos    = ($urandom_range(2, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
            build_idle(0, int'($urandom_range(3, 0)));
            build_eval(0, GA, TA, 0, to_term, 0, cpos, 1'b0);
        end
        build_idle(0, 2);
        for (int k = 0; q.size() > 0; k++) begin
            s = q.pop_front();
            drive_step(0, s, obs);
            total++;
            if (obs !== s.e) begin
                bad++; $display("FAIL random step %0d: got %b want %b", k, obs, s.e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_g3();
        test_grau0();
        test_timeout();
        test_cancel();
        test_hold_done();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
